// File: rtl/lvds_video_fmt_gen.sv
// Programmable panel timing generator with show-ahead pixel fetch, underflow tracking and 4x7 LVDS lane packing.
// Optional colour-bar source is compiled in only when TEST_PATTERN_EN is defined.
module lvds_video_fmt_gen #(
  parameter int H_ACTIVE    = 1024,
  parameter int H_FP        = 160,
  parameter int H_SYNC      = 20,
  parameter int H_BP        = 140,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 12,
  parameter int V_SYNC      = 3,
  parameter int V_BP        = 20,
  parameter int SYNC_POL    = 0,
  parameter int COLOR_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        map_sel,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  input  logic        pix_valid,
  input  logic        pattern_en,
  output logic        pix_req,
  output logic        frame_start,
  output logic        de,
  output logic [27:0] tx_out,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_N    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_N    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic        SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic [27:0] TX_RST  = {7'd0, 4'd0, ~SYNC_ON, ~SYNC_ON, 1'b0, 14'd0};

  logic            r_run;
  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic            r_map;
  logic            r_de;
  logic [27:0]     r_tx_out;
  logic            r_underflow;
  logic [15:0]     r_underflow_cnt;

  logic            w_act;
  logic            w_frame_start;
  logic            w_map;
  logic            w_pat;
  logic            w_fetch;
  logic            w_under;
  logic            w_hs_lvl;
  logic            w_vs_lvl;
  logic [23:0]     w_bar_rgb;
  logic [23:0]     w_rgb;
  logic [7:0]      w_r;
  logic [7:0]      w_g;
  logic [7:0]      w_b;
  logic [6:0]      w_lane0;
  logic [6:0]      w_lane1;
  logic [6:0]      w_lane2;
  logic [6:0]      w_lane3;

  // r_run holds everything idle for one clock after reset so the first request lands on a frame start
  assign w_act         = r_run & (r_h_cnt < H_ACT_N) & (r_v_cnt < V_ACT_N);
  assign w_frame_start = r_run & (r_h_cnt == {HW{1'b0}}) & (r_v_cnt == {VW{1'b0}});
  assign w_map         = w_frame_start ? map_sel : r_map;
  assign w_fetch       = w_act & ~w_pat;
  assign w_under       = w_fetch & ~pix_valid;
  assign w_hs_lvl      = ((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
  assign w_vs_lvl      = ((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END)) ? SYNC_ON : ~SYNC_ON;

`ifdef TEST_PATTERN_EN
  logic            r_pat;
  logic            w_pat_lat;
  logic [HW+2:0]   w_h_x8;
  logic [2:0]      w_bar;

  assign w_pat_lat = w_frame_start ? pattern_en : r_pat;
  assign w_pat     = w_act & w_pat_lat;
  assign w_h_x8    = {r_h_cnt, 3'b000};
  assign w_bar     = 3'(w_h_x8 / (HW+3)'(H_ACTIVE));
  // Bar order white..black: red drops on bar[1], green on bar[2], blue on bar[0]
  assign w_bar_rgb = {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}};

  // Pattern selection takes effect only on frame boundaries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat <= 1'b0;
    end else begin
      r_pat <= w_pat_lat;
    end
  end
`else
  logic w_unused_pattern_en;

  assign w_pat               = 1'b0;
  assign w_bar_rgb           = 24'h000000;
  assign w_unused_pattern_en = pattern_en;
`endif

  // Raster counters: h wraps every line, v advances on each h wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= 1'b0;
      r_h_cnt <= {HW{1'b0}};
      r_v_cnt <= {VW{1'b0}};
    end else if (!r_run) begin
      r_run   <= 1'b1;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= {HW{1'b0}};
      if (r_v_cnt == V_LAST) begin
        r_v_cnt <= {VW{1'b0}};
      end else begin
        r_v_cnt <= r_v_cnt + VW'(1);
      end
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  // Pixel source: pattern, fetched pixel, or black on underflow / blanking
  always_comb begin
    w_rgb = 24'h000000;
    if (w_pat) begin
      w_rgb = w_bar_rgb;
    end else if (w_fetch && pix_valid) begin
      w_rgb = {pix_r, pix_g, pix_b};
    end else begin
      w_rgb = 24'h000000;
    end
  end

  assign w_r = w_rgb[23:16];
  assign w_g = w_rgb[15:8];
  assign w_b = w_rgb[7:0];

  // Lane packing; bit 6 of each lane is serialised first
  always_comb begin
    w_lane0 = 7'd0;
    w_lane1 = 7'd0;
    w_lane2 = 7'd0;
    w_lane3 = 7'd0;
    if (COLOR_DEPTH == 6) begin
      w_lane0 = {w_r[2], w_r[3], w_r[4], w_r[5], w_r[6], w_r[7], w_g[2]};
      w_lane1 = {w_g[3], w_g[4], w_g[5], w_g[6], w_g[7], w_b[2], w_b[3]};
      w_lane2 = {w_b[4], w_b[5], w_b[6], w_b[7], w_hs_lvl, w_vs_lvl, w_act};
      w_lane3 = 7'd0;
    end else if (w_map) begin
      w_lane0 = {w_r[2], w_r[3], w_r[4], w_r[5], w_r[6], w_r[7], w_g[2]};
      w_lane1 = {w_g[3], w_g[4], w_g[5], w_g[6], w_g[7], w_b[2], w_b[3]};
      w_lane2 = {w_b[4], w_b[5], w_b[6], w_b[7], w_hs_lvl, w_vs_lvl, w_act};
      w_lane3 = {w_r[0], w_r[1], w_g[0], w_g[1], w_b[0], w_b[1], 1'b0};
    end else begin
      w_lane0 = {w_r[0], w_r[1], w_r[2], w_r[3], w_r[4], w_r[5], w_g[0]};
      w_lane1 = {w_g[1], w_g[2], w_g[3], w_g[4], w_g[5], w_b[0], w_b[1]};
      w_lane2 = {w_b[2], w_b[3], w_b[4], w_b[5], w_hs_lvl, w_vs_lvl, w_act};
      w_lane3 = {w_r[6], w_r[7], w_g[6], w_g[7], w_b[6], w_b[7], 1'b0};
    end
  end

  // Output stage: one cycle behind the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de     <= 1'b0;
      r_tx_out <= TX_RST;
      r_map    <= 1'b0;
    end else begin
      r_de     <= w_act;
      r_tx_out <= {w_lane3, w_lane2, w_lane1, w_lane0};
      r_map    <= w_map;
    end
  end

  // Sticky underflow flag and saturating event counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underflow     <= 1'b0;
      r_underflow_cnt <= 16'h0000;
    end else if (w_under) begin
      r_underflow <= 1'b1;
      if (r_underflow_cnt != 16'hFFFF) begin
        r_underflow_cnt <= r_underflow_cnt + 16'h0001;
      end
    end
  end

  assign pix_req       = w_fetch;
  assign frame_start   = w_frame_start;
  assign de            = r_de;
  assign tx_out        = r_tx_out;
  assign underflow     = r_underflow;
  assign underflow_cnt = r_underflow_cnt;

endmodule
